pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 145 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Hazard/stall controller for a 5-stage pipeline: load-use bubbles, branch redirect
// flushes, data-memory wait freeze with timeout, and saturating stall/flush counters.
module pipeline_ctrl #(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [4:0]       Rs1_ID,
  input  logic [4:0]       Rs2_ID,
  input  logic [4:0]       Rd_ID_EX,
  input  logic             MemRead_ID_EX,
  input  logic             branch_taken_EX,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             cnt_clr,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             pipe_freeze,
  output logic             err,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    WAIT  = 2'd2,
    ERROR = 2'd3
  } state_t;

  localparam int unsigned WCW = $clog2(TIMEOUT + 1);

  state_t           r_state;
  logic [WCW-1:0]   r_wait_cnt;
  logic             r_flush_pend;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_load_use;
  logic w_mem_busy;
  logic w_freeze;
  logic w_lu_stall;
  logic w_redirect;

  assign w_load_use = MemRead_ID_EX && (Rd_ID_EX != 5'd0) &&
                      ((Rd_ID_EX == Rs1_ID) || (Rd_ID_EX == Rs2_ID));
  assign w_mem_busy = dmem_req && !dmem_ready;

  // Controls are forced to plain pass while reset is held, whatever the state register holds.
  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    pipe_freeze = 1'b0;
    w_freeze    = 1'b0;
    w_lu_stall  = 1'b0;
    w_redirect  = 1'b0;
    if (arst_n) begin
      if (w_mem_busy || (r_state == ERROR)) begin
        w_freeze    = 1'b1;
        pipe_freeze = 1'b1;
        pc_write    = 1'b0;
        if_id_write = 1'b0;
      end else if (branch_taken_EX) begin
        w_redirect  = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (r_state == FLUSH) begin
        if_id_flush = 1'b1;
      end else if ((r_state == RUN) && w_load_use) begin
        w_lu_stall  = 1'b1;
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  assign err       = arst_n && (r_state == ERROR);
  assign state     = r_state;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_state      <= RUN;
      r_wait_cnt   <= '0;
      r_flush_pend <= 1'b0;
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (cnt_clr) begin
        r_stall_cnt <= '0;
        r_flush_cnt <= '0;
      end else begin
        if ((w_freeze || w_lu_stall) && (r_stall_cnt != '1))
          r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        if (w_redirect && (r_flush_cnt != '1))
          r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end

      unique case (r_state)
        RUN: begin
          if (w_mem_busy) begin
            r_state    <= WAIT;
            r_wait_cnt <= WCW'(1);
          end else if (branch_taken_EX) begin
            r_state <= FLUSH;
          end
        end
        FLUSH: begin
          if (w_mem_busy) begin
            r_state      <= WAIT;
            r_wait_cnt   <= WCW'(1);
            r_flush_pend <= 1'b1;
          end else if (branch_taken_EX) begin
            r_state <= FLUSH;
          end else begin
            r_state <= RUN;
          end
        end
        WAIT: begin
          if (w_mem_busy) begin
            if (r_wait_cnt == WCW'(TIMEOUT - 1))
              r_state <= ERROR;
            else
              r_wait_cnt <= r_wait_cnt + WCW'(1);
          end else begin
            r_state      <= r_flush_pend ? FLUSH : RUN;
            r_flush_pend <= 1'b0;
            r_wait_cnt   <= '0;
          end
        end
        ERROR: r_state <= ERROR;
        default: r_state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a rule-level reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_pipeline_ctrl;

  localparam int TO  = 4;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          arst_n;
  logic [4:0]    Rs1_ID, Rs2_ID, Rd_ID_EX;
  logic          MemRead_ID_EX, branch_taken_EX, dmem_req, dmem_ready, cnt_clr;
  logic          pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_freeze, err;
  logic [1:0]    state;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int passed = 0;
  int total  = 0;

  pipeline_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .arst_n(arst_n), .Rs1_ID(Rs1_ID), .Rs2_ID(Rs2_ID), .Rd_ID_EX(Rd_ID_EX),
    .MemRead_ID_EX(MemRead_ID_EX), .branch_taken_EX(branch_taken_EX),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .cnt_clr(cnt_clr),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .pipe_freeze(pipe_freeze), .err(err), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Reference model: state 0=RUN 1=FLUSH 2=WAIT 3=ERROR, counts held as plain ints.
  int m_state = 0, m_wait = 0, m_pend = 0, m_stall = 0, m_flush = 0;
  bit m_valid = 0;

  function automatic bit f_busy();
    return dmem_req && !dmem_ready;
  endfunction

  function automatic bit f_lu();
    return MemRead_ID_EX && (Rd_ID_EX != 0) && (Rd_ID_EX == Rs1_ID || Rd_ID_EX == Rs2_ID);
  endfunction

  // Expected {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_freeze} by priority rules.
  function automatic logic [4:0] f_ctrl();
    if (!arst_n)                    return 5'b11000;
    if (f_busy() || m_state == 3)   return 5'b00001;
    if (branch_taken_EX)            return 5'b11110;
    if (m_state == 1)               return 5'b11100;
    if (m_state == 0 && f_lu())     return 5'b00010;
    return 5'b11000;
  endfunction

  always @(posedge clk) begin : model_upd
    int ns, nw, np, nst, nfl;
    bit frz, lus;
    ns = m_state; nw = m_wait; np = m_pend; nst = m_stall; nfl = m_flush;
    if (!arst_n) begin
      ns = 0; nw = 0; np = 0; nst = 0; nfl = 0;
      m_valid <= 1'b1;
    end else begin
      frz = f_busy() || m_state == 3;
      lus = !frz && !branch_taken_EX && m_state == 0 && f_lu();
      if (cnt_clr) begin
        nst = 0; nfl = 0;
      end else begin
        if ((frz || lus) && nst < SAT) nst++;
        if (branch_taken_EX && !frz && nfl < SAT) nfl++;
      end
      if (m_state == 0) begin
        if (f_busy()) begin ns = 2; nw = 1; end
        else if (branch_taken_EX) ns = 1;
      end else if (m_state == 1) begin
        if (f_busy()) begin ns = 2; nw = 1; np = 1; end
        else if (branch_taken_EX) ns = 1;
        else ns = 0;
      end else if (m_state == 2) begin
        if (f_busy()) begin
          if (m_wait == TO - 1) ns = 3; else nw = m_wait + 1;
        end else begin
          ns = np ? 1 : 0; np = 0; nw = 0;
        end
      end
    end
    m_state <= ns; m_wait <= nw; m_pend <= np; m_stall <= nst; m_flush <= nfl;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("ctrl", {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_freeze}, f_ctrl());
      check("err_state", {err, state}, {(arst_n && m_state == 3), 2'(m_state)});
      check("counters", {stall_cnt, flush_cnt}, {CW'(m_stall), CW'(m_flush)});
    end
  end

  task automatic step(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic mr, input logic br, input logic req, input logic rdy,
                      input logic clr, input logic rst_n);
    @(posedge clk);
    #1;
    Rs1_ID = rs1; Rs2_ID = rs2; Rd_ID_EX = rd; MemRead_ID_EX = mr;
    branch_taken_EX = br; dmem_req = req; dmem_ready = rdy; cnt_clr = clr; arst_n = rst_n;
    #3;
  endtask

  task automatic idle();   step(0, 0, 0, 0, 0, 0, 0, 0, 1); endtask
  task automatic busy();   step(0, 0, 0, 0, 0, 1, 0, 0, 1); endtask
  task automatic branch(); step(0, 0, 0, 0, 1, 0, 0, 0, 1); endtask
  task automatic clear();  step(0, 0, 0, 0, 0, 0, 0, 1, 1); endtask
  task automatic lu5();    step(0, 5, 5, 1, 0, 0, 0, 0, 1); endtask

  initial begin
    // Reset held with hostile inputs: controls must still read as pass.
    arst_n = 1'b0; Rs1_ID = 5'd3; Rs2_ID = 5'd0; Rd_ID_EX = 5'd3; MemRead_ID_EX = 1'b1;
    branch_taken_EX = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0; cnt_clr = 1'b0;
    step(3, 0, 3, 1, 1, 1, 0, 0, 0);
    check("rst_pc_write", pc_write, 1);
    check("rst_freeze", pipe_freeze, 0);
    check("rst_flushes", {if_id_flush, id_ex_flush}, 0);
    step(3, 0, 3, 1, 1, 1, 0, 0, 0);
    check("rst_state", state, 0);
    idle(); idle();
    check("rst_stall_cnt", stall_cnt, 0);

    // Load-use on Rs2, then on Rs1.
    lu5();
    check("lu_pc_write", pc_write, 0);
    check("lu_id_ex_flush", id_ex_flush, 1);
    idle();
    check("lu_release", pc_write, 1);
    check("lu_stall_cnt", stall_cnt, 1);
    step(7, 1, 7, 1, 0, 0, 0, 0, 1);
    check("lu_rs1", id_ex_flush, 1);
    idle();

    // Rd=0 guard and non-load match: no stall.
    step(0, 0, 0, 1, 0, 0, 0, 0, 1);
    check("rd0_pass", {pc_write, if_id_write, id_ex_flush}, 3'b110);
    step(5, 0, 5, 0, 0, 0, 0, 0, 1);
    check("noload_pass", pc_write, 1);
    idle();
    check("rd0_stall_cnt", stall_cnt, 2);

    // Redirect.
    clear(); idle();
    check("clr_flush_cnt", flush_cnt, 0);
    branch();
    check("br_flushes", {if_id_flush, id_ex_flush}, 2'b11);
    idle();
    check("br_flush_state", {state, if_id_flush, id_ex_flush, pc_write}, 5'b01101);
    idle();
    check("br_back_run", {state, if_id_flush}, 3'b000);
    check("br_flush_cnt", flush_cnt, 1);

    // Load-use ignored in FLUSH.
    branch(); lu5();
    check("flush_ignores_lu", {pc_write, id_ex_flush}, 2'b10);
    idle();

    // Memory wait of three busy cycles.
    clear();
    busy();
    check("mw_freeze", {pipe_freeze, pc_write, if_id_write}, 3'b100);
    busy();
    check("mw_state", state, 2);
    busy();
    step(0, 0, 0, 0, 0, 1, 1, 0, 1);
    check("mw_ready", {state, pipe_freeze, pc_write}, 4'b1001);
    idle();
    check("mw_run", state, 0);
    check("mw_stall_cnt", stall_cnt, 3);

    // Wait entered from FLUSH returns through FLUSH.
    clear(); branch();
    busy();
    check("wf_enter", {state, pipe_freeze}, 3'b011);
    busy();
    check("wf_wait", state, 2);
    idle();
    idle();
    check("wf_flush", {state, if_id_flush, id_ex_flush}, 4'b0110);
    idle();
    check("wf_run", state, 0);

    // Branch under freeze is not a redirect.
    step(0, 0, 0, 0, 1, 1, 0, 0, 1);
    check("frz_over_br", {pipe_freeze, if_id_flush}, 2'b10);
    idle(); idle();
    check("frz_br_state", state, 0);

    // Timeout to ERROR, sticky, cleared only by reset.
    clear();
    busy(); busy(); busy(); busy();
    check("to_not_yet", {state, err}, 3'b100);
    busy();
    check("to_error", {state, err}, 3'b111);
    check("to_stall_cnt", stall_cnt, 4);
    idle(); idle();
    check("to_sticky", {err, pipe_freeze}, 2'b11);
    step(0, 0, 0, 0, 1, 1, 0, 0, 0);
    check("to_rst_out", {err, pc_write, pipe_freeze}, 3'b010);
    idle();
    check("to_rst_state", {state, err}, 3'b000);

    // Reset taken in WAIT.
    busy(); busy();
    step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle();
    check("wait_rst", state, 0);

    // Counter saturation and clear priority.
    clear();
    for (int i = 0; i < 20; i++) lu5();
    idle();
    check("stall_sat", stall_cnt, SAT);
    step(0, 5, 5, 1, 0, 0, 0, 1, 1);
    idle();
    check("clr_priority", stall_cnt, 0);
    for (int i = 0; i < 18; i++) branch();
    idle();
    check("flush_sat", flush_cnt, SAT);
    idle(); idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
